apb_master: RTL and testbench
=============================

# apb_master

APB initiator that turns single-word commands from a simple valid/ready command port into APB transfers toward peripheral slaves such as the RTC slave on the same `pclk`/`preset` domain. Each accepted command produces exactly one SETUP→ACCESS APB transfer. A one-cycle response pulse returns the read data, or flags an error if the slave never asserts `pready` within a bounded wait. Used by the processor core and testbenches as the single APB driver.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of ACCESS cycles spent waiting for `pready`; must be ≥ 1.
- `AW`, default 8: APB address width.
- `DW`, default 32: APB data width.

Ports:
- `pclk`  in  1  clock; all state changes on rising edge.
- `preset`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  master can accept a command (high only in IDLE).
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AW  target address (e.g. 8'h00 time, 8'h04 alarm, 8'h08 add/sub).
- `cmd_wdata`  in  DW  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DW  read data; valid with `rsp_valid`.
- `rsp_err`  out  1  timeout flag; valid with `rsp_valid`.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `paddr`  out  AW  APB address.
- `pwdata`  out  DW  APB write data.
- `pready`  in  1  slave ready.
- `prdata`  in  DW  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - `cmd_ready`=1, `psel`=`penable`=0.
  - On `cmd_valid`=1, latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0, `cmd_ready`=0. Unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1. Wait counter starts at 0.
  - `pready`=1 at the edge: complete normally and go to IDLE.
  - `pready`=0: increment the counter. When the counter reaches TIMEOUT, complete with error and go to IDLE.
- Completion registers, visible in the cycle after the completing edge:
  - `rsp_valid`=1.
  - `rsp_err`=0 on normal completion, 1 on timeout.
  - `rsp_rdata`:
    - read with normal completion: `prdata` sampled at the completing edge.
    - write or timeout: 0.
- `rsp_valid` and `rsp_err` are single-cycle pulses. `rsp_rdata` holds its value until the next completion.
- `paddr`, `pwrite`, and `pwdata` remain stable from SETUP through the end of ACCESS and hold their value in IDLE. They change only when a command is accepted.
- Command inputs are ignored while `cmd_ready`=0. There is no queueing.
- `pready` and `prdata` are ignored outside ACCESS.
- Wait counter width is clog2(TIMEOUT+1). It resets to 0 on each entry to SETUP.

## Timing
- Reset (`preset`=0, asynchronous):
  - FSM to IDLE, counter to 0.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, and `rsp_err` go to 0.
  - `paddr` and `pwdata` go to 0, `rsp_rdata` to 0, `cmd_ready` to 1.
  - Reset mid-transfer aborts with no response pulse.
- Accept at edge T (`cmd_valid`&&`cmd_ready`):
  - SETUP in cycle T+1.
  - ACCESS from cycle T+2.
- Zero-wait slave (`pready`=1 in the first ACCESS cycle):
  - `rsp_valid` in cycle T+3, together with `cmd_ready`=1.
  - Minimum command-to-command spacing is 3 cycles.
- Each additional wait-state cycle adds 1 cycle of latency.
- Timeout:
  - ACCESS lasts exactly TIMEOUT cycles.
  - `rsp_valid`/`rsp_err` appear at T+2+TIMEOUT.
- `pready` rising in the same edge where the counter would reach TIMEOUT counts as normal completion (pready wins).
- Back-to-back: a new command may be accepted in the same cycle that `rsp_valid` is high.

## Test plan
- Write, zero-wait slave: cmd write addr 8'h00, data 32'h0000_0E10. Expected:
  - `psel`=1/`penable`=0 at T+1, `penable`=1 at T+2, `paddr`=8'h00, `pwdata`=32'h0000_0E10.
  - At T+3: `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0.
- Read with 2 wait states: slave holds `pready`=0 for 2 ACCESS cycles, then returns `prdata`=32'hDEAD_BEEF with `pready`=1. Expected:
  - `rsp_valid` at T+5, `rsp_rdata`=32'hDEAD_BEEF, `rsp_err`=0.
  - Address and control stable throughout the transfer.
- Timeout (TIMEOUT=16): `pready` held 0. Expected:
  - `penable` high for exactly 16 cycles.
  - At T+18: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
  - Then `psel`=0 and `cmd_ready`=1.
- Late `pready`: slave raises `pready` in the 16th ACCESS cycle with `prdata`=32'h1234_5678. Expected: `rsp_err`=0, `rsp_rdata`=32'h1234_5678.
- Back-to-back plus ignored inputs: `cmd_valid` held high with addr 8'h04 then 8'h08, inputs toggled during SETUP/ACCESS. Expected:
  - Two transfers with addrs 8'h04 then 8'h08, accepted 3 cycles apart.
  - Mid-transfer input changes do not affect `paddr`/`pwdata`.
- Reset mid-ACCESS: assert `preset`=0 asynchronously during a wait state. Expected:
  - All outputs at reset values immediately, before the next `pclk` edge, with no `rsp_valid`.
  - After release, the next command completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB initiator: one valid/ready command becomes one SETUP->ACCESS transfer,
// answered by a single-cycle response pulse carrying read data or a timeout flag.
module apb_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready,
    input  logic [DW-1:0] prdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          cmd_ready_nxt, psel_nxt, penable_nxt, pwrite_nxt;
    logic [AW-1:0] paddr_nxt;
    logic [DW-1:0] pwdata_nxt, rsp_rdata_nxt;
    logic          rsp_valid_nxt, rsp_err_nxt;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_ready <= cmd_ready_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cmd_ready_nxt = cmd_ready;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt     = SETUP;
                    cnt_nxt       = '0;
                    cmd_ready_nxt = 1'b0;
                    psel_nxt      = 1'b1;
                    penable_nxt   = 1'b0;
                    pwrite_nxt    = cmd_write;
                    paddr_nxt     = cmd_addr;
                    pwdata_nxt    = cmd_wdata;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                // pready is checked first so a ready on the final wait cycle is a normal completion
                if (pready || (cnt_inc == CW'(TIMEOUT))) begin
                    state_nxt     = IDLE;
                    cmd_ready_nxt = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = !pready;
                    rsp_rdata_nxt = (pready && !pwrite) ? prdata : '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: the stimulus side queues the expected response
// of every accepted command, and a monitor pops and compares on each rsp_valid.
module tb_apb_master;

    localparam int TMO = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;

    apb_master #(.TIMEOUT(TMO), .AW(8), .DW(32)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          pen;
    } exp_t;
    exp_t q[$];

    // slave behaviour: pready after slave_waits ACCESS cycles, never if negative
    int          slave_waits = 0;
    logic [31:0] slave_data = '0;

    logic [7:0]  cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic        cur_write = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int acc = 0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                pready = (slave_waits >= 0) && (acc == slave_waits);
                prdata = pready ? slave_data : (32'hBAD0_0000 ^ 32'(cyc));
                acc++;
            end else begin
                acc    = 0;
                pready = 1'b1;
                prdata = 32'h5A5A_0000 ^ 32'(cyc);
            end
        end
    end

    initial begin
        int          pen = 0;
        bit          prev = 0;
        logic [31:0] last = '0;
        exp_t        e;
        forever begin
            @(negedge pclk);
            if (!preset) begin
                pen  = 0;
                prev = 0;
            end else begin
                check("paddr_stable", 32'(paddr), 32'(cur_addr));
                check("pwdata_stable", pwdata, cur_wdata);
                check("pwrite_stable", 32'(pwrite), 32'(cur_write));
                if (prev && !rsp_valid) begin
                    check("rsp_err_pulse", 32'(rsp_err), 32'd0);
                    check("rsp_rdata_hold", rsp_rdata, last);
                end
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 required no response (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                        check("penable_cycles", 32'(pen), 32'(e.pen));
                        check("rsp_psel", 32'(psel), 32'd0);
                        check("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
                    end
                    last = rsp_rdata;
                    pen  = 0;
                end else if (penable) begin
                    pen++;
                end
                prev = rsp_valid;
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] sdata, input bit keep,
                         output int acc);
        int   guard = 0;
        bit   terr;
        exp_t e;
        @(negedge pclk);
        while (!cmd_ready && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_wait: got cmd_ready=0 after 100 cycles expected 1");
        end
        slave_waits = waits;
        slave_data  = sdata;
        cmd_valid   = 1'b1;
        cmd_write   = w;
        cmd_addr    = a;
        cmd_wdata   = d;
        @(posedge pclk);
        #1;
        acc       = cyc;
        cur_addr  = a;
        cur_wdata = d;
        cur_write = w;
        terr      = (waits < 0) || (waits >= TMO);
        e.err     = terr;
        e.rdata   = (w || terr) ? 32'd0 : sdata;
        e.pen     = terr ? TMO : waits + 1;
        e.cyc     = terr ? acc + 1 + TMO : acc + 2 + waits;
        q.push_back(e);
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        // scramble command inputs while busy; they must be ignored
        cmd_write = ~w;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
        cmd_valid = keep;
        @(posedge pclk);
        #1;
        check("access_psel", 32'(psel), 32'd1);
        check("access_penable", 32'(penable), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_psel"}, 32'(psel), 32'd0);
        check({tag, "_penable"}, 32'(penable), 32'd0);
        check({tag, "_pwrite"}, 32'(pwrite), 32'd0);
        check({tag, "_paddr"}, 32'(paddr), 32'd0);
        check({tag, "_pwdata"}, pwdata, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        int a0, a1, a2;
        int guard;
        repeat (2) @(posedge pclk);
        #1;
        check_reset_outputs("reset");
        @(negedge pclk);
        preset = 1'b1;

        issue(1'b1, 8'h00, 32'h0000_0E10, 0, 32'h0, 1'b0, a0);
        issue(1'b0, 8'h04, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, a0);
        issue(1'b0, 8'h08, 32'h0, -1, 32'hFFFF_FFFF, 1'b0, a0);
        issue(1'b0, 8'h00, 32'h0, 15, 32'h1234_5678, 1'b0, a0);

        issue(1'b1, 8'h04, 32'hA5A5_0001, 0, 32'h0, 1'b1, a1);
        issue(1'b0, 8'h08, 32'hA5A5_0002, 0, 32'h7777_0008, 1'b0, a2);
        check("b2b_spacing", 32'(a2 - a1), 32'd3);

        // abort a transfer that is stuck in wait states
        issue(1'b0, 8'h04, 32'h0, -1, 32'h0, 1'b0, a0);
        repeat (3) @(posedge pclk);
        #3;
        preset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        cur_addr  = '0;
        cur_wdata = '0;
        cur_write = 1'b0;
        q.delete();
        @(negedge pclk);
        preset = 1'b1;

        issue(1'b0, 8'h08, 32'h0, 1, 32'hCAFE_F00D, 1'b0, a0);

        guard = 0;
        while (q.size() > 0 && guard < 300) begin
            @(negedge pclk);
            guard++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_pending: got %0d outstanding responses expected 0", q.size());
        end
        repeat (2) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
